// File: rtl/cpu_types_pkg.sv
// Shared pipeline types for the five-stage MIPS core.
//   pcsel_t : redirect select, same encoding the control unit produces
//   ifid_t  : IF/ID pipeline latch contents
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    PC_NEXT   = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_JR     = 2'b11
  } pcsel_t;

  typedef struct packed {
    word_t instr;
    word_t npc;
    logic  valid;
  } ifid_t;

  // SLL $0,$0,0 encodes as all zeros, so the bubble is a real NOP.
  localparam word_t NOP_INSTR = 32'h0000_0000;
  localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, npc: 32'h0, valid: 1'b0};

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC target selection.
//   pc, pcsel, redirect_npc, imm16, jaddr, jr_addr -> target
//   pc_plus4 : sequential PC (wraps mod 2^32)
// Branch and jump targets are relative to the redirecting instruction's
// PC+4, not the current fetch PC, so this is reusable by later stages.
module next_pc_calc
  import cpu_types_pkg::*;
(
  input  word_t       pc,
  input  pcsel_t      pcsel,
  input  word_t       redirect_npc,
  input  logic [15:0] imm16,
  input  logic [25:0] jaddr,
  input  word_t       jr_addr,
  output word_t       pc_plus4,
  output word_t       target
);

  word_t br_target;
  word_t j_target;

  assign pc_plus4  = pc + 32'd4;
  assign br_target = redirect_npc + {{14{imm16[15]}}, imm16, 2'b00};
  assign j_target  = {redirect_npc[31:28], jaddr, 2'b00};

  always_comb begin
    target = pc_plus4;
    unique case (pcsel)
      PC_NEXT:   target = pc_plus4;
      PC_BRANCH: target = br_target;
      PC_JUMP:   target = j_target;
      PC_JR:     target = jr_addr;
      default:   target = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, imem read request, redirects,
// IF/ID latch, stall/flush/halt handling.
//   CLK, RST (sync, active-high)
//   ihit/imemload/imemREN/imemaddr : instruction memory
//   stall/flush/halt               : hazard and decode control
//   pcsel/redirect_npc/imm16/jaddr/jr_addr : downstream-resolved redirect
//   ifid_instr/ifid_npc/ifid_valid : IF/ID latch
//   halted                          : sticky halt status
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        flush,
  input  logic        halt,
  input  logic [1:0]  pcsel,
  input  logic [31:0] redirect_npc,
  input  logic [15:0] imm16,
  input  logic [25:0] jaddr,
  input  logic [31:0] jr_addr,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_npc,
  output logic        ifid_valid,
  output logic        halted
);

  word_t  pc_q;
  ifid_t  ifid_q;
  logic   halted_q;
  word_t  pc_plus4;
  word_t  target;
  pcsel_t sel;

  assign sel = pcsel_t'(pcsel);

  next_pc_calc u_next_pc (
    .pc           (pc_q),
    .pcsel        (sel),
    .redirect_npc (redirect_npc),
    .imm16        (imm16),
    .jaddr        (jaddr),
    .jr_addr      (jr_addr),
    .pc_plus4     (pc_plus4),
    .target       (target)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q     <= PC_INIT;
      ifid_q   <= IFID_BUBBLE;
      halted_q <= 1'b0;
    end else if (halted_q) begin
      // Frozen until reset; redirects and flushes are ignored.
      ifid_q <= IFID_BUBBLE;
    end else if (sel != PC_NEXT) begin
      // Redirect beats stall: the in-flight fetch is wrong-path anyway.
      // A same-cycle halt came from a squashed instruction.
      pc_q   <= target;
      ifid_q <= IFID_BUBBLE;
    end else if (flush) begin
      ifid_q <= IFID_BUBBLE;
      if (ihit && !stall) pc_q <= pc_plus4;
    end else if (halt) begin
      halted_q <= 1'b1;
      ifid_q   <= IFID_BUBBLE;
    end else if (stall) begin
      // hold PC and IF/ID
    end else if (ihit) begin
      pc_q   <= pc_plus4;
      ifid_q <= '{instr: imemload, npc: pc_plus4, valid: 1'b1};
    end else begin
      ifid_q <= IFID_BUBBLE;
    end
  end

  assign imemaddr   = pc_q;
  assign imemREN    = !halted_q;
  assign ifid_instr = ifid_q.instr;
  assign ifid_npc   = ifid_q.npc;
  assign ifid_valid = ifid_q.valid;
  assign halted     = halted_q;

endmodule
